// File: rtl/kbd_key_decoder_if.sv
// Byte stream from the PS/2 receiver into the key decoder.
// One byte per din_valid strobe.
interface kbd_key_decoder_if;
  logic [7:0] din;
  logic       din_valid;

  modport master (
    output din,
    output din_valid
  );

  modport slave (
    input din,
    input din_valid
  );
endinterface

// File: rtl/kbd_key_decoder.sv
// PS/2 set-2 scan-code decoder: held levels for arrows and space,
// plus a one-shot pulse when space goes down.
module kbd_key_decoder #(
  parameter logic [7:0] CODE_SPACE  = 8'h29,
  parameter logic [7:0] CODE_LEFT   = 8'h6B,
  parameter logic [7:0] CODE_RIGHT  = 8'h74,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               resetN,
  kbd_key_decoder_if.slave   bus,
  input  logic               clearKeys,
  output logic               rightArrow,
  output logic               leftArrow,
  output logic               spaceBar,
  output logic               spacePress
);

  localparam int CW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            timeout;

  logic is_e0;
  logic is_f0;
  logic is_sp;
  logic is_l;
  logic is_r;

  logic set_sp;
  logic clr_sp;
  logic set_l;
  logic clr_l;
  logic set_r;
  logic clr_r;

  assign is_e0 = (bus.din == 8'hE0);
  assign is_f0 = (bus.din == 8'hF0);
  assign is_sp = (bus.din == CODE_SPACE);
  assign is_l  = (bus.din == CODE_LEFT);
  assign is_r  = (bus.din == CODE_RIGHT);

  assign timeout = (state != IDLE) &&
                   (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte arriving on the timeout cycle still completes its sequence.
  always_comb begin
    state_nxt = state;
    if (clearKeys) begin
      state_nxt = IDLE;
    end else if (bus.din_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_e0:   state_nxt = GOT_E0;
            is_f0:   state_nxt = GOT_F0;
            default: state_nxt = IDLE;
          endcase
        end
        GOT_E0: begin
          unique case (1'b1)
            is_f0:   state_nxt = GOT_E0F0;
            is_e0:   state_nxt = GOT_E0;
            default: state_nxt = IDLE;
          endcase
        end
        GOT_F0: begin
          unique case (1'b1)
            is_e0:   state_nxt = GOT_E0;
            is_f0:   state_nxt = GOT_F0;
            default: state_nxt = IDLE;
          endcase
        end
        GOT_E0F0: begin
          unique case (1'b1)
            is_e0:   state_nxt = GOT_E0;
            is_f0:   state_nxt = GOT_E0F0;
            default: state_nxt = IDLE;
          endcase
        end
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    set_sp = 1'b0;
    clr_sp = 1'b0;
    set_l  = 1'b0;
    clr_l  = 1'b0;
    set_r  = 1'b0;
    clr_r  = 1'b0;
    if (bus.din_valid && !clearKeys) begin
      unique case (state)
        IDLE: begin
          set_sp = is_sp;
        end
        GOT_E0: begin
          set_l = is_l;
          set_r = is_r;
        end
        GOT_F0: begin
          clr_sp = is_sp;
        end
        GOT_E0F0: begin
          clr_l = is_l;
          clr_r = is_r;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rightArrow <= 1'b0;
      leftArrow  <= 1'b0;
      spaceBar   <= 1'b0;
      spacePress <= 1'b0;
    end else if (clearKeys) begin
      rightArrow <= 1'b0;
      leftArrow  <= 1'b0;
      spaceBar   <= 1'b0;
      spacePress <= 1'b0;
    end else begin
      rightArrow <= set_r | (rightArrow & ~clr_r);
      leftArrow  <= set_l | (leftArrow & ~clr_l);
      spaceBar   <= set_sp | (spaceBar & ~clr_sp);
      spacePress <= set_sp & ~spaceBar;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clearKeys || bus.din_valid) begin
      cnt <= '0;
    end else if (state == IDLE || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_kbd_key_decoder.sv
// Scoreboard bench for kbd_key_decoder.
// Outputs are packed as {right, left, space, press}.
module tb_kbd_key_decoder;

  localparam int T = 8;

  logic clk;
  logic resetN;
  logic clearKeys;
  logic rightArrow;
  logic leftArrow;
  logic spaceBar;
  logic spacePress;

  int n_cmp;
  int n_bad;

  logic [3:0] exp_q[$];
  logic [3:0] outs;

  kbd_key_decoder_if bus ();

  kbd_key_decoder #(
    .TIMEOUT_CYC (T)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .bus        (bus),
    .clearKeys  (clearKeys),
    .rightArrow (rightArrow),
    .leftArrow  (leftArrow),
    .spaceBar   (spaceBar),
    .spacePress (spacePress)
  );

  assign outs = {rightArrow, leftArrow, spaceBar, spacePress};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %b expected <empty queue>", tag, outs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, outs, e);
    end
  endtask

  task automatic send(
    input string      tag,
    input logic [7:0] b,
    input logic [3:0] e
  );
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_chk(tag);
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic idle_chk(
    input string      tag,
    input logic [3:0] e
  );
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  task automatic clear_with(
    input string      tag,
    input logic [7:0] b,
    input logic [3:0] e
  );
    @(negedge clk);
    clearKeys     = 1'b1;
    bus.din       = b;
    bus.din_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_chk(tag);
    @(negedge clk);
    clearKeys     = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    resetN        = 1'b0;
    clearKeys     = 1'b0;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    pop_chk("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // space make, typematic, break
    send("sp_make", 8'h29, 4'b0011);
    idle_chk("sp_pulse_end", 4'b0010);
    send("sp_rep1", 8'h29, 4'b0010);
    send("sp_rep2", 8'h29, 4'b0010);
    send("sp_f0", 8'hF0, 4'b0010);
    send("sp_break", 8'h29, 4'b0000);

    // both arrows held, release right only
    send("r_e0", 8'hE0, 4'b0000);
    send("r_make", 8'h74, 4'b1000);
    send("l_e0", 8'hE0, 4'b1000);
    send("l_make", 8'h6B, 4'b1100);
    send("r_e0b", 8'hE0, 4'b1100);
    send("r_f0b", 8'hF0, 4'b1100);
    send("r_break", 8'h74, 4'b0100);

    clear_with("clr_plain", 8'h00, 4'b0000);

    // keypad codes and extended 29 are ignored
    send("kp6", 8'h74, 4'b0000);
    send("kp4", 8'h6B, 4'b0000);
    send("e0_29a", 8'hE0, 4'b0000);
    send("e0_29b", 8'h29, 4'b0000);
    send("after_e029", 8'h74, 4'b0000);
    send("e1", 8'hE1, 4'b0000);
    send("after_e1", 8'h74, 4'b0000);

    // prefix still live just before the timeout
    send("to_e0a", 8'hE0, 4'b0000);
    repeat (T - 3) @(posedge clk);
    send("to_live", 8'h74, 4'b1000);
    send("to_rel_e0", 8'hE0, 4'b1000);
    send("to_rel_f0", 8'hF0, 4'b1000);
    send("to_rel", 8'h74, 4'b0000);

    // prefix abandoned after the timeout
    send("to_e0b", 8'hE0, 4'b0000);
    repeat (T + 1) @(posedge clk);
    send("to_dead", 8'h74, 4'b0000);

    // timeout in GOT_F0 keeps space held
    send("tf_make", 8'h29, 4'b0011);
    send("tf_f0", 8'hF0, 4'b0010);
    repeat (T + 1) @(posedge clk);
    send("tf_rep", 8'h29, 4'b0010);
    send("tf_f0b", 8'hF0, 4'b0010);
    send("tf_break", 8'h29, 4'b0000);

    // clear beats a same-cycle F0
    send("cl_make", 8'h29, 4'b0011);
    clear_with("cl_f0", 8'hF0, 4'b0000);
    send("cl_remake", 8'h29, 4'b0011);
    idle_chk("cl_pulse_end", 4'b0010);
    send("cl_f0b", 8'hF0, 4'b0010);
    send("cl_break", 8'h29, 4'b0000);

    // reset while in GOT_E0F0
    send("rs_e0", 8'hE0, 4'b0000);
    send("rs_make", 8'h6B, 4'b0100);
    send("rs_e0b", 8'hE0, 4'b0100);
    send("rs_f0", 8'hF0, 4'b0100);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    pop_chk("rs_async");
    @(negedge clk);
    resetN = 1'b1;
    send("rs_after", 8'h6B, 4'b0000);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
